// File: rtl/exu_fp_seq.sv
// Single-issue sequencer in front of NUM_UNITS floating-point units: accepts one
// request, starts the selected unit, waits for its result (or a timeout) and responds.
module exu_fp_seq #(
  parameter int WIDTH     = 32,
  parameter int NUM_UNITS = 3,
  parameter int TIMEOUT   = 64,
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       req_valid,
  input  logic [UW-1:0]              req_unit,
  input  logic [WIDTH-1:0]           req_op1,
  input  logic [WIDTH-1:0]           req_op2,
  output logic                       req_ready,
  input  logic                       flush,
  output logic [NUM_UNITS-1:0]       unit_start,
  output logic [WIDTH-1:0]           unit_a,
  output logic [WIDTH-1:0]           unit_b,
  input  logic [NUM_UNITS-1:0]       unit_done,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_result,
  output logic                       resp_valid,
  output logic [WIDTH-1:0]           resp_data,
  output logic [UW-1:0]              resp_unit,
  output logic                       resp_timeout,
  output logic                       fp_stall
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_reg, state_next;
  logic [UW-1:0]        unit_reg;
  logic [WIDTH-1:0]     unit_a_reg, unit_b_reg;
  logic [CW-1:0]        cnt_reg;
  logic [WIDTH-1:0]     resp_data_reg;
  logic [UW-1:0]        resp_unit_reg;
  logic                 resp_timeout_reg;

  logic [NUM_UNITS-1:0] req_hit_vec;
  logic [NUM_UNITS-1:0] cur_sel_vec;
  logic [WIDTH-1:0]     sel_result;
  logic                 req_bad;
  logic                 done_sel;
  logic                 timeout_hit;
  logic                 accept;

  // Index decode is done by explicit compare so out-of-range indices never select a unit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      assign req_hit_vec[gi] = (req_unit == UW'(gi));
      assign cur_sel_vec[gi] = (unit_reg == UW'(gi));
      assign unit_start[gi]  = (state_reg == ISSUE) && cur_sel_vec[gi];
    end
  endgenerate

  always_comb begin
    sel_result = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (cur_sel_vec[i]) sel_result = sel_result | unit_result[i*WIDTH +: WIDTH];
    end
  end

  assign req_bad     = ~|req_hit_vec;
  assign done_sel    = |(unit_done & cur_sel_vec);
  assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == TO_LAST);
  assign accept      = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = req_bad ? RESP : ISSUE;
      ISSUE: state_next = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush)                         state_next = IDLE;
        else if (done_sel || timeout_hit)  state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = rst_l && (state_reg == IDLE) && !flush;
    resp_valid = (state_reg == RESP) && !flush;
    fp_stall   = rst_l && ((state_reg != IDLE) || (req_valid && !req_ready));
  end

  // Response registers load only on entry to RESP; done takes priority over expiry.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      unit_reg         <= '0;
      unit_a_reg       <= '0;
      unit_b_reg       <= '0;
      cnt_reg          <= '0;
      resp_data_reg    <= '0;
      resp_unit_reg    <= '0;
      resp_timeout_reg <= 1'b0;
    end else begin
      if (accept) begin
        unit_reg   <= req_unit;
        unit_a_reg <= req_op1;
        unit_b_reg <= req_op2;
      end
      if (state_reg == ISSUE) begin
        cnt_reg <= '0;
      end else if (state_reg == WAIT && cnt_reg != '1) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (accept && req_bad) begin
        resp_data_reg    <= '0;
        resp_unit_reg    <= req_unit;
        resp_timeout_reg <= 1'b1;
      end else if (state_reg == WAIT && !flush) begin
        if (done_sel) begin
          resp_data_reg    <= sel_result;
          resp_unit_reg    <= unit_reg;
          resp_timeout_reg <= 1'b0;
        end else if (timeout_hit) begin
          resp_data_reg    <= '0;
          resp_unit_reg    <= unit_reg;
          resp_timeout_reg <= 1'b1;
        end
      end
    end
  end

  assign unit_a       = unit_a_reg;
  assign unit_b       = unit_b_reg;
  assign resp_data    = resp_data_reg;
  assign resp_unit    = resp_unit_reg;
  assign resp_timeout = resp_timeout_reg;

endmodule

// File: tb/tb_exu_fp_seq.sv
// Randomized bench for exu_fp_seq: a per-operation outcome model (response cycle,
// data, timeout) derived from latency/flush/index rules, plus directed corner cases.
module tb_exu_fp_seq;

  localparam int NU = 3;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        req_valid;
  logic [1:0]  req_unit;
  logic [31:0] req_op1, req_op2;
  logic        req_ready;
  logic        flush;
  logic [2:0]  unit_start;
  logic [31:0] unit_a, unit_b;
  logic [2:0]  unit_done;
  logic [95:0] unit_result;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_unit;
  logic        resp_timeout;
  logic        fp_stall;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_data = '0;
  logic [1:0]  last_unit = '0;
  logic        last_to   = 1'b0;

  exu_fp_seq #(.WIDTH(32), .NUM_UNITS(NU), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_unit(req_unit), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .flush(flush),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_result(unit_result),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_unit(resp_unit),
    .resp_timeout(resp_timeout), .fp_stall(fp_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // One operation, offset 0 = accept cycle. lat<0 means the unit never answers.
  task automatic do_op(input int unit, input logic [31:0] op1, input logic [31:0] op2,
                       input logic [31:0] res, input int lat, input int flush_in,
                       input int spur_unit, input int spur_off, input int tail);
    bit          bad, has_resp, reached;
    int          resp_off, end_off, done_off, last_off, flush_off;
    logic [31:0] exp_data, hold_data;
    logic [1:0]  hold_unit;
    logic        exp_to, hold_to;
    logic [2:0]  exp_start;

    bad = (unit >= NU);
    if (bad) begin
      resp_off = 1; exp_data = '0; exp_to = 1'b1;
    end else if (lat >= 0 && lat <= TO - 1) begin
      resp_off = 3 + lat; exp_data = res; exp_to = 1'b0;
    end else begin
      resp_off = TO + 2; exp_data = '0; exp_to = 1'b1;
    end
    flush_off = (flush_in > resp_off) ? -1 : flush_in;
    has_resp  = !(flush_off >= 1 && flush_off <= resp_off);
    reached   = !(flush_off >= 1 && flush_off < resp_off);
    end_off   = has_resp ? resp_off : flush_off;
    done_off  = (!bad && lat >= 0) ? 2 + lat : -1;
    last_off  = ((done_off > end_off) ? done_off : end_off) + tail;
    exp_start = bad ? 3'b000 : 3'(1 << unit);

    unit_result = {$urandom, $urandom, $urandom};
    if (!bad) unit_result[unit*32 +: 32] = res;

    for (int off = 0; off <= last_off; off++) begin
      @(negedge clk);
      req_valid = (off == 0);
      req_unit  = 2'(unit);
      req_op1   = op1;
      req_op2   = op2;
      flush     = (off == flush_off);
      unit_done = '0;
      if (off == done_off) unit_done[unit] = 1'b1;
      if (spur_unit >= 0 && off == spur_off) unit_done[spur_unit] = 1'b1;
      #1;
      if (off == 0) begin
        chk("accept_ready", req_ready, 1);
        chk("accept_stall", fp_stall, 0);
      end
      if (off == 1) begin
        if (flush_off != 1) chk("unit_start", unit_start, exp_start);
        chk("unit_a", unit_a, op1);
        chk("unit_b", unit_b, op2);
        chk("busy_stall", fp_stall, 1);
      end
      if (off == 2 && end_off > 2) chk("start_pulse_end", unit_start, 0);
      chk("resp_valid", resp_valid, (has_resp && off == resp_off) ? 1 : 0);
      if (off >= 1) begin
        hold_data = (reached && off >= resp_off) ? exp_data : last_data;
        hold_unit = (reached && off >= resp_off) ? 2'(unit) : last_unit;
        hold_to   = (reached && off >= resp_off) ? exp_to : last_to;
        chk("resp_data", resp_data, hold_data);
        chk("resp_unit", resp_unit, hold_unit);
        chk("resp_timeout", resp_timeout, hold_to);
      end
      if (off > end_off) chk("ready_after", req_ready, 1);
    end
    if (reached) begin
      last_data = exp_data; last_unit = 2'(unit); last_to = exp_to;
    end
    $display("[TB] op unit=%0d lat=%0d flush=%0d resp=%0b off=%0d data=%h to=%0b",
             unit, lat, flush_off, has_resp, resp_off, exp_data, exp_to);
  endtask

  initial begin
    rst_l = 1'b0; req_valid = 1'b0; req_unit = '0; req_op1 = '0; req_op2 = '0;
    flush = 1'b0; unit_done = '0; unit_result = '0;

    // Reset behaviour, including a pending request during reset.
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_stall", fp_stall, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_unit_a", unit_a, 0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_l = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 1);
    $display("[TB] reset released");

    // Directed cases.
    do_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 2, -1, -1, 0, 0);  // add, L=2
    do_op(2, 32'h11111111, 32'h22222222, 32'hDEADBEEF, -1, -1, -1, 0, 1); // timeout
    do_op(1, 32'h0, 32'h1, 32'h12345678, 3, -1, 0, 3, 0);                 // wrong-unit done
    do_op(0, 32'h5, 32'h6, 32'hCAFEF00D, 2, 4, -1, 0, 0);                 // flush on done
    do_op(2, 32'h7, 32'h8, 32'h0BADCAFE, 0, -1, -1, 0, 0);                // back-to-back, L=0
    do_op(3, 32'h9, 32'hA, 32'h0, 0, -1, -1, 0, 1);                       // bad index
    do_op(1, 32'hB, 32'hC, 32'hA5A5A5A5, 7, -1, -1, 0, 0);                // done == expiry
    do_op(1, 32'hD, 32'hE, 32'h5A5A5A5A, 8, -1, -1, 0, 0);                // done after expiry
    do_op(0, 32'hF, 32'h10, 32'h600DF00D, 1, 4, -1, 0, 1);                // flush in RESP
    do_op(2, 32'h1, 32'h2, 32'h13579BDF, 3, 1, -1, 0, 0);                 // flush in ISSUE

    // Flush while idle blocks acceptance.
    @(negedge clk);
    req_valid = 1'b1; req_unit = 2'd1; flush = 1'b1;
    #1;
    chk("idle_flush_ready", req_ready, 0);
    chk("idle_flush_stall", fp_stall, 1);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    chk("idle_flush_no_start", unit_start, 0);
    chk("idle_flush_no_stall", fp_stall, 0);
    $display("[TB] idle flush blocked accept");

    // Reset mid-WAIT discards the operation.
    @(negedge clk);
    req_valid = 1'b1; req_unit = 2'd1; req_op1 = 32'h77; req_op2 = 32'h88;
    #1;
    chk("rw_accept", req_ready, 1);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    chk("rw_stall", fp_stall, 0);
    chk("rw_start", unit_start, 0);
    chk("rw_ready", req_ready, 0);
    chk("rw_unit_a", unit_a, 0);
    chk("rw_resp_to", resp_timeout, 0);
    @(negedge clk);
    rst_l = 1'b1;
    last_data = '0; last_unit = '0; last_to = 1'b0;
    #1;
    chk("rw_ready_release", req_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      unit_done = (c == 0) ? 3'b010 : 3'b000;
      #1;
      chk("rw_no_resp", resp_valid, 0);
    end
    unit_done = '0;
    $display("[TB] reset mid-wait discarded operation");

    // Randomized operations.
    for (int n = 0; n < 60; n++) begin
      int u, l, f, su, so;
      u  = int'($urandom_range(0, 3));
      l  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
      f  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 11)) : -1;
      su = ($urandom_range(0, 1) == 0) ? -1 : (u + 1 + int'($urandom_range(0, 1))) % 3;
      so = int'($urandom_range(2, 10));
      do_op(u, $urandom, $urandom, $urandom, l, f, su, so, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
